// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load formatting, result select and
// arbitration of the single register-file write port against a late-result FIFO.
// Ports: Clock/Reset (async, active-low), Stall/Flush control the stage register,
//   MEM_* carry the instruction from MEM, Late_* offer multi-cycle results
//   (Late_Ready = FIFO not full), RegWrite/WriteAddress/WriteData drive the RF,
//   RetireCount counts committed writes.
// Optional: define WB_RETIRE_CNT_EN to build the RetireCount counter;
//   otherwise RetireCount is tied to 0.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int QDEPTH = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              MEM_RegWrite,
   input  logic [1:0]        MEM_MemToReg,
   input  logic [1:0]        MEM_ByteSel,
   input  logic [ADDR_W-1:0] MEM_WriteAddress,
   input  logic [DATA_W-1:0] MEM_ALUResult,
   input  logic [DATA_W-1:0] MEM_ReadData,
   input  logic [DATA_W-1:0] MEM_PCPlus8,
   input  logic              Late_Valid,
   input  logic [ADDR_W-1:0] Late_Address,
   input  logic [DATA_W-1:0] Late_Data,
   output logic              Late_Ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteAddress,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       RetireCount
);

   localparam int PW = $clog2(QDEPTH);
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0] CNT_ONE = 1;
   localparam logic [PW:0] CNT_FULL = QDEPTH[PW:0];

   logic              stRegWrite;
   logic [1:0]        stMemToReg;
   logic [1:0]        stByteSel;
   logic [ADDR_W-1:0] stAddr;
   logic [DATA_W-1:0] stAlu;
   logic [DATA_W-1:0] stRead;
   logic [DATA_W-1:0] stPc8;
   logic              done;

   logic [ADDR_W-1:0] qAddr [QDEPTH];
   logic [DATA_W-1:0] qData [QDEPTH];
   logic [PW-1:0]     wrPtr;
   logic [PW-1:0]     rdPtr;
   logic [PW:0]       count;

   logic              pipeReq;
   logic              push;
   logic              pop;
   logic [7:0]        byteVal;
   logic [15:0]       halfVal;
   logic [DATA_W-1:0] loadVal;
   logic [DATA_W-1:0] stResult;

   // Big-endian lanes: lane 0 is the most significant byte.
   always_comb begin
      byteVal = '0;
      unique case (stAlu[1:0])
         2'b00: byteVal = stRead[DATA_W-1 -: 8];
         2'b01: byteVal = stRead[DATA_W-9 -: 8];
         2'b10: byteVal = stRead[DATA_W-17 -: 8];
         2'b11: byteVal = stRead[DATA_W-25 -: 8];
      endcase
   end

   // Misaligned halfwords ignore address bit 0.
   assign halfVal = stAlu[1] ? stRead[DATA_W-17 -: 16]
                             : stRead[DATA_W-1 -: 16];

   always_comb begin
      loadVal = stRead;
      unique case (stByteSel)
         2'b00: loadVal = stRead;
         2'b01: loadVal = {{(DATA_W-16){halfVal[15]}}, halfVal};
         2'b10: loadVal = {{(DATA_W-8){byteVal[7]}}, byteVal};
         2'b11: loadVal = {{(DATA_W-8){1'b0}}, byteVal};
      endcase
   end

   always_comb begin
      stResult = stAlu;
      unique case (stMemToReg)
         2'b01:   stResult = loadVal;
         2'b10:   stResult = stPc8;
         default: stResult = stAlu;
      endcase
   end

   // done keeps a stalled instruction from writing more than once.
   assign pipeReq = stRegWrite & ~done & (stAddr != '0);
   assign Late_Ready = (count != CNT_FULL);
   assign push = Late_Valid & Late_Ready;

   // Pipeline always wins; a late entry to r0 is drained silently.
   always_comb begin
      RegWrite = 1'b0;
      WriteAddress = '0;
      WriteData = '0;
      pop = 1'b0;
      if (pipeReq) begin
         RegWrite = 1'b1;
         WriteAddress = stAddr;
         WriteData = stResult;
      end else if (count != '0) begin
         pop = 1'b1;
         if (qAddr[rdPtr] != '0) begin
            RegWrite = 1'b1;
            WriteAddress = qAddr[rdPtr];
            WriteData = qData[rdPtr];
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stRegWrite <= 1'b0;
         stMemToReg <= '0;
         stByteSel <= '0;
         stAddr <= '0;
         stAlu <= '0;
         stRead <= '0;
         stPc8 <= '0;
         done <= 1'b0;
      end else if (Flush) begin
         stRegWrite <= 1'b0;
         stMemToReg <= '0;
         stByteSel <= '0;
         stAddr <= '0;
         stAlu <= '0;
         stRead <= '0;
         stPc8 <= '0;
         done <= 1'b0;
      end else if (Stall) begin
         done <= done | pipeReq;
      end else begin
         stRegWrite <= MEM_RegWrite;
         stMemToReg <= MEM_MemToReg;
         stByteSel <= MEM_ByteSel;
         stAddr <= MEM_WriteAddress;
         stAlu <= MEM_ALUResult;
         stRead <= MEM_ReadData;
         stPc8 <= MEM_PCPlus8;
         done <= 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (push) begin
         qAddr[wrPtr] <= Late_Address;
         qData[wrPtr] <= Late_Data;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_ONE;
         if (pop) rdPtr <= rdPtr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retireCnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) retireCnt <= '0;
      else if (RegWrite) retireCnt <= retireCnt + 32'd1;
   end

   assign RetireCount = retireCnt;
`else
   assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed plus randomized checks of wb_stage against a
// transaction-level model (formatted values, a queue of late results).
module tb_wb_stage;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int QDEPTH = 2;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Stall, Flush;
   logic        MEM_RegWrite;
   logic [1:0]  MEM_MemToReg, MEM_ByteSel;
   logic [4:0]  MEM_WriteAddress;
   logic [31:0] MEM_ALUResult, MEM_ReadData, MEM_PCPlus8;
   logic        Late_Valid;
   logic [4:0]  Late_Address;
   logic [31:0] Late_Data;
   logic        Late_Ready, RegWrite;
   logic [4:0]  WriteAddress;
   logic [31:0] WriteData, RetireCount;

   wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
      .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
      .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
      .MEM_ByteSel(MEM_ByteSel), .MEM_WriteAddress(MEM_WriteAddress),
      .MEM_ALUResult(MEM_ALUResult), .MEM_ReadData(MEM_ReadData),
      .MEM_PCPlus8(MEM_PCPlus8), .Late_Valid(Late_Valid),
      .Late_Address(Late_Address), .Late_Data(Late_Data),
      .Late_Ready(Late_Ready), .RegWrite(RegWrite),
      .WriteAddress(WriteAddress), .WriteData(WriteData),
      .RetireCount(RetireCount)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   int nChk = 0;
   int nErr = 0;

   bit          mRw;
   bit          mDone;
   logic [4:0]  mAddr;
   logic [31:0] mVal;
   logic [31:0] mRet;
   ent_t        mQ[$];

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fmt(logic [1:0] m, logic [1:0] bs,
                                       logic [31:0] alu, logic [31:0] rd,
                                       logic [31:0] pc8);
      int k;
      logic [31:0] b, h;
      if (m == 2'd2) return pc8;
      if (m != 2'd1) return alu;
      k = int'(alu[1:0]);
      b = (rd >> (24 - 8 * k)) & 32'hFF;
      h = alu[1] ? (rd & 32'hFFFF) : (rd >> 16);
      case (bs)
         2'd0: return rd;
         2'd1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
         2'd2: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
         default: return b;
      endcase
   endfunction

   function automatic logic [31:0] expRet();
`ifdef WB_RETIRE_CNT_EN
      return mRet;
`else
      return 32'd0;
`endif
   endfunction

   task automatic idle();
      Stall = 0; Flush = 0;
      MEM_RegWrite = 0; MEM_MemToReg = 0; MEM_ByteSel = 0;
      MEM_WriteAddress = 0; MEM_ALUResult = 0; MEM_ReadData = 0;
      MEM_PCPlus8 = 0; Late_Valid = 0; Late_Address = 0; Late_Data = 0;
   endtask

   task automatic alu(logic [4:0] a, logic [31:0] v);
      MEM_RegWrite = 1; MEM_MemToReg = 0; MEM_ByteSel = 0;
      MEM_WriteAddress = a; MEM_ALUResult = v;
   endtask

   task automatic late(logic [4:0] a, logic [31:0] d);
      Late_Valid = 1; Late_Address = a; Late_Data = d;
   endtask

   // Compare every output with the model, then advance one clock.
   task automatic step();
      bit pr, eRw, pop, push;
      logic [4:0] eA;
      logic [31:0] eD;
      pr = mRw && !mDone && (mAddr != 0);
      eRw = 0; eA = 0; eD = 0; pop = 0;
      if (pr) begin
         eRw = 1; eA = mAddr; eD = mVal;
      end else if (mQ.size() > 0) begin
         pop = 1;
         if (mQ[0].a != 0) begin
            eRw = 1; eA = mQ[0].a; eD = mQ[0].d;
         end
      end
      chk("RegWrite", 32'(RegWrite), 32'(eRw));
      chk("WriteAddress", 32'(WriteAddress), 32'(eA));
      chk("WriteData", WriteData, eD);
      chk("Late_Ready", 32'(Late_Ready), 32'(mQ.size() < QDEPTH));
      chk("RetireCount", RetireCount, expRet());
      push = Late_Valid && (mQ.size() < QDEPTH);
      if (pop) void'(mQ.pop_front());
      if (push) mQ.push_back('{Late_Address, Late_Data});
      if (eRw) mRet = mRet + 32'd1;
      if (Flush) begin
         mRw = 0; mDone = 0;
      end else if (Stall) begin
         mDone = mDone | pr;
      end else begin
         mRw = MEM_RegWrite; mAddr = MEM_WriteAddress; mDone = 0;
         mVal = fmt(MEM_MemToReg, MEM_ByteSel, MEM_ALUResult,
                    MEM_ReadData, MEM_PCPlus8);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic doReset();
      Reset = 0;
      #2;
      mRw = 0; mDone = 0; mAddr = 0; mVal = 0; mRet = 0;
      mQ.delete();
      chk("rst_RegWrite", 32'(RegWrite), 32'd0);
      chk("rst_WriteAddress", 32'(WriteAddress), 32'd0);
      chk("rst_WriteData", WriteData, 32'd0);
      chk("rst_Late_Ready", 32'(Late_Ready), 32'd1);
      chk("rst_RetireCount", RetireCount, 32'd0);
      @(posedge Clock);
      #1;
      Reset = 1;
   endtask

   initial begin
      idle();
      @(posedge Clock);
      #1;
      doReset();

      // Fill the FIFO behind pipeline writes, then reset mid-stream.
      alu(5'd7, 32'h700); late(5'd3, 32'h11); step();
      alu(5'd7, 32'h701); late(5'd4, 32'h22); step();
      chk("pre_rst_full", 32'(Late_Ready), 32'd0);
      idle();
      doReset();
      for (int i = 0; i < 3; i++) begin
         chk("queued_dropped", 32'(RegWrite), 32'd0);
         step();
      end

      // ALU write.
      alu(5'd8, 32'h1234); step();
      idle();
      chk("alu_rw", 32'(RegWrite), 32'd1);
      chk("alu_addr", 32'(WriteAddress), 32'd8);
      chk("alu_data", WriteData, 32'h00001234);
      step();
`ifdef WB_RETIRE_CNT_EN
      chk("alu_retire", RetireCount, 32'd1);
`endif

      // Loads from 0x80FF7F01.
      MEM_RegWrite = 1; MEM_MemToReg = 2'd1; MEM_ReadData = 32'h80FF7F01;
      MEM_ByteSel = 2'd2; MEM_ALUResult = 32'h100; MEM_WriteAddress = 5'd10;
      step();
      MEM_ByteSel = 2'd3; MEM_WriteAddress = 5'd11;
      chk("lb_signed", WriteData, 32'hFFFFFF80);
      step();
      MEM_ByteSel = 2'd1; MEM_ALUResult = 32'h102; MEM_WriteAddress = 5'd12;
      chk("lbu", WriteData, 32'h00000080);
      step();
      idle();
      chk("lh_lane1", WriteData, 32'h00007F01);
      step();

      // Stall three cycles on r5 with r9 queued.
      alu(5'd5, 32'h55); late(5'd9, 32'hAA); step();
      idle(); Stall = 1;
      chk("stall1_addr", 32'(WriteAddress), 32'd5);
      step();
      chk("stall2_rw", 32'(RegWrite), 32'd1);
      chk("stall2_addr", 32'(WriteAddress), 32'd9);
      chk("stall2_data", WriteData, 32'hAA);
      step();
      chk("stall3_rw", 32'(RegWrite), 32'd0);
      step();
      Stall = 0; step();

      // Late results wait while the pipeline owns the port.
      alu(5'd7, 32'h700); late(5'd3, 32'h11); step();
      alu(5'd7, 32'h701); late(5'd4, 32'h22); step();
      idle();
      chk("full_ready", 32'(Late_Ready), 32'd0);
      chk("full_pipe", 32'(WriteAddress), 32'd7);
      step();
      chk("late1_addr", 32'(WriteAddress), 32'd3);
      chk("late1_data", WriteData, 32'h11);
      step();
      chk("late2_addr", 32'(WriteAddress), 32'd4);
      chk("late2_data", WriteData, 32'h22);
      step();

      // Flush with Stall, then a write to r0.
      alu(5'd6, 32'h66); step();
      idle(); Flush = 1; Stall = 1;
      chk("flush_pre", 32'(WriteAddress), 32'd6);
      step();
      idle();
      chk("flush_bubble", 32'(RegWrite), 32'd0);
      step();
      alu(5'd0, 32'hDEAD); step();
      idle();
      chk("r0_rw", 32'(RegWrite), 32'd0);
      step();
`ifdef WB_RETIRE_CNT_EN
      chk("retire_total", RetireCount, 32'd11);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            idle();
            doReset();
         end
         Stall = ($urandom_range(0, 4) == 0);
         Flush = ($urandom_range(0, 9) == 0);
         MEM_RegWrite = ($urandom_range(0, 3) != 0);
         MEM_MemToReg = 2'($urandom_range(0, 3));
         MEM_ByteSel = 2'($urandom_range(0, 3));
         MEM_WriteAddress = ($urandom_range(0, 7) == 0) ? 5'd0
                            : 5'($urandom_range(1, 31));
         MEM_ALUResult = $urandom;
         MEM_ReadData = $urandom;
         MEM_PCPlus8 = $urandom;
         Late_Valid = ($urandom_range(0, 9) < 4);
         Late_Address = ($urandom_range(0, 7) == 0) ? 5'd0
                        : 5'($urandom_range(1, 31));
         Late_Data = $urandom;
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
      $finish;
   end

endmodule
